uart_autobaud_detect: RTL and testbench

//  Measures the bit period of an incoming 0x55 ('U') sync character on the UART rx line.

---
 rtl/uart_autobaud_detect.sv | 164 ++++++++++++++++
 tb/tb_uart_autobaud_detect.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_autobaud_detect.sv
// Auto-baud detector: times a 0x55 sync character on rx and produces the
// 16x-oversampling divisor for the baud generator that shares this clock.
module uart_autobaud_detect #(
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYC    = 16,
    parameter int MIN_BIT     = 16,
    parameter int TOL_SHIFT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        rx,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] div_out
);

    localparam int IW = $clog2(IDLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_WAIT_START, S_MEASURE, S_CALC, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        E_NONE = 2'b00, E_SHORT = 2'b01, E_TOL = 2'b10, E_RANGE = 2'b11
    } err_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic [IW-1:0]          idle_cnt_q;
    logic [CNT_W-1:0]       ival_q, total_q, ref_q;
    logic [3:0]             edge_idx_q;
    err_t                   code_q;
    logic                   busy_q, done_q, err_q;
    logic [1:0]             err_code_q;
    logic [15:0]            div_q;

    logic                   rx_s, fall_det, edge_det, cnt_full;
    logic [CNT_W-1:0]       diff_d, tol_d;
    logic [CNT_W:0]         q_d;
    logic [3:0]             edge_n_d;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign fall_det = rx_prev_q & ~rx_s;
    assign edge_det = rx_prev_q ^ rx_s;
    assign cnt_full = (ival_q == '1) || (total_q == '1);
    assign diff_d   = (ival_q >= ref_q) ? (ival_q - ref_q) : (ref_q - ival_q);
    assign tol_d    = ref_q >> TOL_SHIFT;
    // Divide total (8 bit times) by 128 with rounding: 8 bits x 16 oversampling.
    assign q_d      = ({1'b0, total_q} + (CNT_W+1)'(64)) >> 7;
    assign edge_n_d = edge_idx_q + 4'd1;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign div_out  = div_q;

    // NOTE: all state updates use <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            // NOTE: synchronizer resets to the idle level so reset release
            // cannot fake a falling edge.
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            idle_cnt_q <= '0;
            ival_q     <= '0;
            total_q    <= '0;
            ref_q      <= '0;
            edge_idx_q <= '0;
            code_q     <= E_NONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            div_q      <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
            rx_prev_q <= rx_s;
            done_q    <= 1'b0;
            err_q     <= 1'b0;

            if (abort && state_q != S_IDLE) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state_q    <= S_WAIT_IDLE;
                            busy_q     <= 1'b1;
                            idle_cnt_q <= '0;
                            err_code_q <= 2'b00;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (!rx_s)
                            idle_cnt_q <= '0;
                        else if (idle_cnt_q == IW'(IDLE_CYC - 1))
                            state_q <= S_WAIT_START;
                        else
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                    S_WAIT_START: begin
                        if (fall_det) begin
                            state_q    <= S_MEASURE;
                            ival_q     <= '0;
                            total_q    <= '0;
                            edge_idx_q <= '0;
                        end
                    end
                    S_MEASURE: begin
                        ival_q  <= ival_q + 1'b1;
                        total_q <= total_q + 1'b1;
                        if (cnt_full) begin
                            state_q <= S_ERR;
                            code_q  <= E_RANGE;
                        end else if (edge_det) begin
                            ival_q     <= CNT_W'(1);
                            edge_idx_q <= edge_n_d;
                            if (edge_idx_q == 4'd0) begin
                                ref_q <= ival_q;
                                if (ival_q < CNT_W'(MIN_BIT)) begin
                                    state_q <= S_ERR;
                                    code_q  <= E_SHORT;
                                end
                            end else if (diff_d > tol_d) begin
                                state_q <= S_ERR;
                                code_q  <= E_TOL;
                            end else if (edge_n_d == 4'd8) begin
                                state_q <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        if (q_d < (CNT_W+1)'(2) || q_d > (CNT_W+1)'(16'hFFFF)) begin
                            state_q <= S_ERR;
                            code_q  <= E_RANGE;
                        end else begin
                            state_q <= S_IDLE;
                            div_q   <= q_d[15:0];
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_ERR: begin
                        state_q    <= S_IDLE;
                        err_q      <= 1'b1;
                        err_code_q <= code_q;
                        busy_q     <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_detect.sv
// Scoreboard bench for uart_autobaud_detect: each driven sync character pushes
// its expected outcome, a negedge monitor pops and compares on done/err.
module tb_uart_autobaud_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rx = 1'b1;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] div_out;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [15:0] div;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total_n = 0;
    int          bad_n = 0;
    int          cyc = 0;
    int          e8_cyc = 0;
    logic [15:0] last_div = '0;

    uart_autobaud_detect dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rx(rx),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .div_out(div_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: first interval reads one short (ival starts at 0), later ones
    // exact; total spans e0..e8; divisor rounds total/128.
    function automatic exp_t model(input int iv[8]);
        exp_t e;
        int rf, d, sum, q;
        e.is_err = 1'b1;
        e.div    = last_div;
        e.code   = 2'b00;
        rf = iv[0] - 1;
        if (rf < 16) begin
            e.code = 2'b01;
            return e;
        end
        sum = iv[0];
        for (int k = 1; k < 8; k++) begin
            d = iv[k] - rf;
            if (d < 0) d = -d;
            if (d > (rf >> 2)) begin
                e.code = 2'b10;
                return e;
            end
            sum += iv[k];
        end
        q = (sum + 64) >> 7;
        if (q < 2 || q > 65535) begin
            e.code = 2'b11;
            return e;
        end
        e.is_err = 1'b0;
        e.div    = q[15:0];
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            total_n++;
            if (done && err) begin
                bad_n++;
                $display("FAIL done_err_both done=%0b err=%0b required not both", done, err);
            end
            if (exp_q.size() == 0) begin
                total_n++;
                bad_n++;
                $display("FAIL unexpected_pulse done=%0b err=%0b at cyc %0d", done, err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                total_n += 4;
                if (err !== mon_e.is_err) begin
                    bad_n++;
                    $display("FAIL outcome_err got=%0b want=%0b", err, mon_e.is_err);
                end
                if (err_code !== mon_e.code) begin
                    bad_n++;
                    $display("FAIL err_code got=%0b want=%0b", err_code, mon_e.code);
                end
                if (div_out !== mon_e.div) begin
                    bad_n++;
                    $display("FAIL div_out got=%0d want=%0d", div_out, mon_e.div);
                end
                if (busy !== 1'b0) begin
                    bad_n++;
                    $display("FAIL busy_at_pulse got=%0b want=0", busy);
                end
                if (done && !mon_e.is_err) begin
                    total_n++;
                    if (cyc !== e8_cyc + 4) begin
                        bad_n++;
                        $display("FAIL done_latency got=%0d want=%0d", cyc - e8_cyc, 4);
                    end
                end
            end
        end
    end

    task automatic hold_rx(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // act: 0 none, 1 abort, 2 start (must be ignored), 3 rst; applied at edge act_k.
    task automatic send_char(input int iv[8], input int act_k, input int act);
        exp_t e;
        logic lvl;
        int   n;
        if (act == 0 || act == 2) begin
            e = model(iv);
            exp_q.push_back(e);
            if (!e.is_err) last_div = e.div;
        end
        lvl = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            rx = lvl;
            if (k == 8) e8_cyc = cyc;
            n = (k < 8) ? iv[k] : iv[7];
            if (k == act_k && act != 0) begin
                if (act == 1) abort = 1'b1;
                if (act == 2) start = 1'b1;
                if (act == 3) rst = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                start = 1'b0;
                rst   = 1'b0;
                n--;
                if (act == 1) begin
                    total_n++;
                    if (busy !== 1'b0) begin
                        bad_n++;
                        $display("FAIL abort_busy got=%0b want=0", busy);
                    end
                end
                if (act == 3) begin
                    total_n++;
                    if ({busy, done, err, err_code, div_out} !== 21'd0) begin
                        bad_n++;
                        $display("FAIL reset_mid busy=%0b done=%0b err=%0b code=%0b div=%0d want all 0",
                                 busy, done, err, err_code, div_out);
                    end
                    last_div = '0;
                end
            end
            repeat (n) @(posedge clk);
            #1;
            lvl = ~lvl;
        end
        hold_rx(1'b1, iv[7] + 20);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        total_n++;
        if (exp_q.size() != 0) begin
            bad_n++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_n++;
        if ({busy, done, err, err_code, div_out} !== 21'd0) begin
            bad_n++;
            $display("FAIL reset_state busy=%0b done=%0b err=%0b code=%0b div=%0d want all 0",
                     busy, done, err, err_code, div_out);
        end
        rst = 1'b0;
        hold_rx(1'b1, 5);
        total_n++;
        if (busy !== 1'b0) begin
            bad_n++;
            $display("FAIL idle_busy got=%0b want=0", busy);
        end
    endtask

    task automatic test_rate(input int p, input int act_k, input int act);
        int iv[8];
        iv = '{default: p};
        pulse_start();
        total_n++;
        if (busy !== 1'b1) begin
            bad_n++;
            $display("FAIL start_busy got=%0b want=1", busy);
        end
        hold_rx(1'b1, 30);
        send_char(iv, act_k, act);
        wait_drain(200);
    endtask

    task automatic test_tolerance();
        int iv[8];
        iv = '{default: 500};
        iv[3] = 650;
        pulse_start();
        hold_rx(1'b1, 30);
        send_char(iv, 0, 0);
        wait_drain(200);
    endtask

    task automatic test_short_start();
        int   g[8];
        exp_t e;
        g = '{default: 0};
        g[0] = 10;
        pulse_start();
        hold_rx(1'b1, 30);
        e = model(g);
        exp_q.push_back(e);
        hold_rx(1'b0, 10);
        hold_rx(1'b1, 40);
        wait_drain(200);
    endtask

    task automatic test_idle_qualify();
        hold_rx(1'b0, 10);
        pulse_start();
        hold_rx(1'b0, 40);
        hold_rx(1'b1, 10);
        hold_rx(1'b0, 10);
        hold_rx(1'b1, 30);
        begin
            int iv[8];
            iv = '{default: 200};
            send_char(iv, 0, 0);
        end
        wait_drain(200);
    endtask

    task automatic test_abort();
        test_rate(300, 4, 1);
        total_n++;
        if (busy !== 1'b0) begin
            bad_n++;
            $display("FAIL abort_idle got=%0b want=0", busy);
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        hold_rx(1'b1, 2);
        total_n++;
        if (busy !== 1'b0) begin
            bad_n++;
            $display("FAIL start_abort_same got=%0b want=0", busy);
        end
        test_rate(20, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rate(868, 0, 0);
        test_rate(104, 3, 2);
        test_tolerance();
        test_short_start();
        test_idle_qualify();
        test_abort();
        test_rate(100, 2, 3);
        hold_rx(1'b1, 20);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
